// File: rtl/mode_state_machine.sv
`default_nettype none
// ============================================================================
// Module   : mode_state_machine
// Purpose  : Central mode register for the exhaust hood. Arbitrates the
//            one-cycle toggle requests from the per-mode controllers, owns
//            current_mode and runs the timed phases (hurricane run,
//            hurricane standby-return, self-clean).
// Revision : 1.0  initial release
// ============================================================================
module mode_state_machine #(
  parameter int MODE_WIDTH     = 3,
  parameter int TICKS_PER_SEC  = 100000000,
  parameter int HURRICANE_SECS = 60,
  parameter int RETURN_SECS    = 60,
  parameter int CLEAN_SECS     = 180,
  parameter logic [MODE_WIDTH-1:0] OFF_MODE       = 3'd0,
  parameter logic [MODE_WIDTH-1:0] STANDBY_MODE   = 3'd1,
  parameter logic [MODE_WIDTH-1:0] LEVEL1_MODE    = 3'd2,
  parameter logic [MODE_WIDTH-1:0] LEVEL2_MODE    = 3'd3,
  parameter logic [MODE_WIDTH-1:0] HURRICANE_MODE = 3'd4,
  parameter logic [MODE_WIDTH-1:0] CLEAN_MODE     = 3'd5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  power_on_toggle,
  input  logic                  off_mode_toggle,
  input  logic                  standby_toggle,
  input  logic                  level1_toggle,
  input  logic                  level2_toggle,
  input  logic                  level3_toggle,
  input  logic                  clean_toggle,
  output logic [MODE_WIDTH-1:0] current_mode,
  output logic [7:0]            remaining_secs,
  output logic                  hurricane_used,
  output logic                  returning,
  output logic                  clean_done
);

  // A one-tick-per-cycle configuration still needs a 1-bit counter.
  localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST     = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [7:0]         HURRICANE_LOAD = 8'(HURRICANE_SECS);
  localparam logic [7:0]         RETURN_LOAD    = 8'(RETURN_SECS);
  localparam logic [7:0]         CLEAN_LOAD     = 8'(CLEAN_SECS);

  typedef enum logic [MODE_WIDTH-1:0] {
    ST_OFF       = OFF_MODE,
    ST_STANDBY   = STANDBY_MODE,
    ST_LEVEL1    = LEVEL1_MODE,
    ST_LEVEL2    = LEVEL2_MODE,
    ST_HURRICANE = HURRICANE_MODE,
    ST_CLEAN     = CLEAN_MODE
  } mode_t;

  mode_t              state, state_d;
  logic [7:0]         secs, secs_d;
  logic [PRESC_W-1:0] presc, presc_d;
  logic               used, used_d;
  logic               ret, ret_d;
  logic               done, done_d;
  logic               timed;
  logic               tick;

  assign current_mode   = state;
  assign remaining_secs = secs;
  assign hurricane_used = used;
  assign returning      = ret;
  assign clean_done     = done;

  // State and timer registers; reset returns every output to its idle value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_OFF;
      secs  <= 8'd0;
      presc <= '0;
      used  <= 1'b0;
      ret   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      secs  <= secs_d;
      presc <= presc_d;
      used  <= used_d;
      ret   <= ret_d;
      done  <= done_d;
    end
  end

  // Next-state arbitration: in each state only the legal toggles are
  // examined, in priority order, so an illegal higher-priority toggle never
  // masks a legal lower-priority one and never disturbs the timers.
  always_comb begin
    state_d = state;
    secs_d  = secs;
    used_d  = used;
    ret_d   = ret;
    done_d  = 1'b0;
    timed   = (state == ST_HURRICANE) || (state == ST_CLEAN);
    tick    = timed && (presc == PRESC_LAST);

    // Free-running second prescaler while a timed phase is active.
    if (!timed)    presc_d = '0;
    else if (tick) presc_d = '0;
    else           presc_d = presc + PRESC_W'(1);

    case (state)
      ST_OFF: begin
        if (power_on_toggle) state_d = ST_STANDBY;
      end

      ST_STANDBY: begin
        if (off_mode_toggle) begin
          state_d = ST_OFF;
        end else if (level3_toggle && !used) begin
          state_d = ST_HURRICANE;
          secs_d  = HURRICANE_LOAD;
          presc_d = '0;
          used_d  = 1'b1;
          ret_d   = 1'b0;
        end else if (level2_toggle) begin
          state_d = ST_LEVEL2;
        end else if (level1_toggle) begin
          state_d = ST_LEVEL1;
        end else if (clean_toggle) begin
          state_d = ST_CLEAN;
          secs_d  = CLEAN_LOAD;
          presc_d = '0;
        end
      end

      ST_LEVEL1: begin
        if (off_mode_toggle)     state_d = ST_OFF;
        else if (standby_toggle) state_d = ST_STANDBY;
        else if (level2_toggle)  state_d = ST_LEVEL2;
      end

      ST_LEVEL2: begin
        if (off_mode_toggle)     state_d = ST_OFF;
        else if (standby_toggle) state_d = ST_STANDBY;
        else if (level1_toggle)  state_d = ST_LEVEL1;
      end

      ST_HURRICANE: begin
        if (off_mode_toggle) begin
          state_d = ST_OFF;
        end else if (standby_toggle && !ret) begin
          // Start the standby-return countdown; mode stays HURRICANE.
          ret_d   = 1'b1;
          secs_d  = RETURN_LOAD;
          presc_d = '0;
        end else if (tick) begin
          if (secs == 8'd1) begin
            state_d = ret ? ST_STANDBY : ST_LEVEL2;
            secs_d  = 8'd0;
            ret_d   = 1'b0;
          end else if (secs != 8'd0) begin
            secs_d = secs - 8'd1;
          end
        end
      end

      ST_CLEAN: begin
        if (off_mode_toggle) begin
          state_d = ST_OFF;
        end else if (tick) begin
          if (secs == 8'd1) begin
            state_d = ST_STANDBY;
            secs_d  = 8'd0;
            done_d  = 1'b1;
          end else if (secs != 8'd0) begin
            secs_d = secs - 8'd1;
          end
        end
      end

      default: begin
        state_d = ST_OFF;
      end
    endcase

    // Untimed destinations carry no countdown state.
    if ((state_d != ST_HURRICANE) && (state_d != ST_CLEAN)) begin
      secs_d  = 8'd0;
      ret_d   = 1'b0;
      presc_d = '0;
    end

    // hurricane_used is cleared only by reaching OFF.
    if (state_d == ST_OFF) used_d = 1'b0;
  end

endmodule
`default_nettype wire

// File: doc/mode_state_machine.md
Name: mode_state_machine

Overview:
- Central mode register for the exhaust hood. It consumes the one-cycle toggle requests produced by the per-mode controllers: power-on, off, standby, level 1/2/3 and self-clean.
- It owns current_mode, which every controller reads back, and the timed modes (hurricane, self-clean).
- It sits directly downstream of the off-mode controller. It also drives the fan/display logic.

Parameters:
MODE_WIDTH, 3, width of current_mode
TICKS_PER_SEC, 100000000, clk cycles per one-second tick
HURRICANE_SECS, 60, hurricane run time before dropping to level 2
RETURN_SECS, 60, delay from standby request in hurricane until STANDBY
CLEAN_SECS, 180, self-clean duration
OFF_MODE, 3'd0, encoding; STANDBY_MODE 3'd1, LEVEL1_MODE 3'd2, LEVEL2_MODE 3'd3, HURRICANE_MODE 3'd4, CLEAN_MODE 3'd5

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
power_on_toggle  input  1  one-cycle request OFF->STANDBY
off_mode_toggle  input  1  one-cycle request any->OFF
standby_toggle  input  1  one-cycle request to STANDBY
level1_toggle  input  1  one-cycle request LEVEL1
level2_toggle  input  1  one-cycle request LEVEL2
level3_toggle  input  1  one-cycle request HURRICANE
clean_toggle  input  1  one-cycle request CLEAN
current_mode  output  MODE_WIDTH  registered mode
remaining_secs  output  8  seconds left in the active timed phase; 0 otherwise
hurricane_used  output  1  set when HURRICANE is entered; cleared only in OFF/reset
returning  output  1  high during the hurricane standby-return countdown
clean_done  output  1  one-cycle pulse when CLEAN completes naturally

Behaviour:
- Reset and clocking: synchronous, active-high, applied on the clk edge.
  - Reset value: current_mode=OFF_MODE, remaining_secs=0, hurricane_used=0, returning=0, clean_done=0.
  - The tick prescaler and seconds counter are also cleared.
- Register latency: all outputs are registered. A toggle sampled in cycle N changes current_mode in cycle N+1.
- Priority among simultaneous toggles: off > power_on > standby > level3 > level2 > level1 > clean. Only the highest legal request is honoured; the others are dropped.
- Toggles are not legal in every state. An illegal toggle is ignored and must not affect the timers.
- Off is universal: off_mode_toggle in any non-OFF state -> OFF.
  - In the same cycle: remaining_secs=0, returning=0, timers cleared, hurricane_used cleared.
- OFF:
  - power_on_toggle -> STANDBY.
  - All other toggles are ignored.
- STANDBY:
  - level1 -> LEVEL1; level2 -> LEVEL2; clean -> CLEAN.
  - level3 -> HURRICANE only if hurricane_used=0; otherwise ignored.
- LEVEL1 / LEVEL2:
  - The other level's toggle switches level directly; standby -> STANDBY.
  - level3 and clean are ignored.
- HURRICANE entry: remaining_secs=HURRICANE_SECS, prescaler cleared, hurricane_used set.
- HURRICANE countdown: each TICKS_PER_SEC cycles remaining_secs decrements.
  - When a tick lands with remaining_secs==1 -> LEVEL2 and remaining_secs=0.
- HURRICANE standby request (returning=0): returning=1, remaining_secs reloads RETURN_SECS, prescaler cleared.
  - Mode stays HURRICANE during the return countdown.
  - Tick at 1 -> STANDBY, returning=0.
- HURRICANE, further requests: level toggles are ignored while in HURRICANE. A repeated standby is ignored while returning=1.
- CLEAN entry: remaining_secs=CLEAN_SECS, prescaler cleared.
- CLEAN completion: tick at 1 -> STANDBY, with clean_done pulsed in that same cycle.
  - Only off_mode_toggle is honoured in CLEAN.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 only while in a timed phase; otherwise held at 0.
  - Width is $clog2(TICKS_PER_SEC).
  - remaining_secs never underflows.
- Outside a timed phase: remaining_secs=0, returning=0.
- Reset mid-countdown: everything returns to its reset value on the next edge.

Test Plan:
All scenarios use TICKS_PER_SEC=4, HURRICANE_SECS=3, RETURN_SECS=2, CLEAN_SECS=5.
1. Power-up: reset, then power_on pulse -> current_mode=1 one cycle later; level2 pulse -> 3; standby pulse -> 1.
2. Hurricane:
   - From STANDBY, level3 pulse -> mode=4, remaining_secs=3, hurricane_used=1.
   - After 12 cycles -> mode=3.
   - Then standby, then level3 -> mode stays 1 (one-shot).
3. Hurricane return: enter HURRICANE, standby pulse 2 cycles later -> returning=1, remaining_secs=2, mode=4; 8 cycles later -> mode=1, returning=0.
4. Clean: from STANDBY, clean pulse -> mode=5, remaining_secs=5; 20 cycles later -> mode=1 with clean_done=1 for exactly one cycle.
5. Priority and abort:
   - off+level1 same cycle in LEVEL2 -> mode=0, hurricane_used=0.
   - off pulse mid-CLEAN -> mode=0, remaining_secs=0, no clean_done.
6. Reset: rst asserted mid-hurricane countdown -> next edge mode=0, remaining_secs=0, returning=0. In OFF, level1/clean pulses -> mode stays 0.
